// File: rtl/mat_key_scan.sv
// Matrix keypad scanner. Drives one row low per slot, samples the columns,
// debounces each key over DB_DEPTH frames and queues press/release events
// in a small FIFO for a ready/valid consumer.
module mat_key_scan #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DB_DEPTH       = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic [ROWS-1:0]                 row_n,
    input  logic [COLS-1:0]                 col_in,
    output logic [ROWS*COLS-1:0]            btn,
    output logic                            frame_tick,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [$clog2(ROWS*COLS)-1:0]    evt_code,
    output logic                            evt_press,
    output logic                            overflow,
    input  logic                            clr_ovf
);

    localparam int NKEY = ROWS * COLS;
    localparam int CW   = $clog2(NKEY);
    localparam int SW   = $clog2(SCAN_DIV);
    localparam int RW   = $clog2(ROWS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    logic [SW-1:0]       slot_cnt;
    logic [RW-1:0]       row_idx;
    logic                slot_last;
    logic                row_last;
    logic [COLS-1:0]     col_s;
    logic [COLS-1:0]     row_lat [ROWS];
    logic [NKEY-1:0]     frame_smp;
    logic [DB_DEPTH-1:0] hist     [NKEY];
    logic [DB_DEPTH-1:0] hist_nxt [NKEY];
    logic [NKEY-1:0]     btn_nxt;
    logic [NKEY-1:0]     pending;
    logic [NKEY-1:0]     pend_clr;
    logic [NKEY-1:0]     pend_set;
    logic [CW-1:0]       lo_idx;
    logic                lo_found;
    logic [CW:0]         fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [CNTW-1:0]     count;
    logic                push;
    logic                pop;
    logic                full;
    logic                push_ok;

    assign slot_last  = (slot_cnt == SW'(SCAN_DIV - 1));
    assign row_last   = (row_idx == RW'(ROWS - 1));
    assign frame_tick = slot_last && row_last && !rst;
    assign row_n      = ~(ROWS'(1) << row_idx);
    assign col_s      = (COL_ACTIVE_LOW != 0) ? ~col_in : col_in;

    // Slot timer and row pointer; the row advances on every slot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            row_idx  <= '0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            row_idx  <= row_last ? '0 : row_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Capture the column sense of the active row on the last cycle of its slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) row_lat[r] <= '0;
        end else if (slot_last) begin
            row_lat[row_idx] <= col_s;
        end
    end

    // Assemble the full-frame sample; the last row is taken live because its
    // latch is only being written on the same edge.
    always_comb begin
        frame_smp = '0;
        for (int r = 0; r < ROWS; r++) begin
            frame_smp[r*COLS +: COLS] = (r == ROWS - 1) ? col_s : row_lat[r];
        end
    end

    // Post-shift history and debounced level for every key.
    always_comb begin
        btn_nxt = btn;
        for (int k = 0; k < NKEY; k++) begin
            hist_nxt[k] = {hist[k][DB_DEPTH-2:0], frame_smp[k]};
            if (&hist_nxt[k]) begin
                btn_nxt[k] = 1'b1;
            end else if (hist_nxt[k] == '0) begin
                btn_nxt[k] = 1'b0;
            end
        end
    end

    // Commit histories and debounced levels once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NKEY; k++) hist[k] <= '0;
            btn <= '0;
        end else if (frame_tick) begin
            for (int k = 0; k < NKEY; k++) hist[k] <= hist_nxt[k];
            btn <= btn_nxt;
        end
    end

    // Lowest-index pending key is the next event to push.
    always_comb begin
        lo_idx   = '0;
        lo_found = 1'b0;
        for (int k = 0; k < NKEY; k++) begin
            if (pending[k] && !lo_found) begin
                lo_idx   = CW'(k);
                lo_found = 1'b1;
            end
        end
    end

    assign pend_clr = lo_found ? (NKEY'(1) << lo_idx) : '0;
    assign pend_set = frame_tick ? (btn_nxt ^ btn) : '0;

    // Pending vector: mark changed keys at the btn update, retire one per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    assign push      = lo_found;
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    assign full      = (count == CNTW'(FIFO_DEPTH));
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok   = push && (!full || pop);

    // Event storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wptr] <= {lo_idx, btn[lo_idx]};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign evt_code  = fifo_mem[rptr][CW:1];
    assign evt_press = fifo_mem[rptr][0];

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && !push_ok) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mat_key_scan.sv
// Directed bench for mat_key_scan with a 4x4 matrix, 4-cycle slots,
// 4-frame debounce and a 4-entry event FIFO.
module tb_mat_key_scan;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_in;
    logic [15:0] btn;
    logic        frame_tick;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_code;
    logic        evt_press;
    logic        overflow;
    logic        clr_ovf;

    logic [15:0] keys;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [4:0]  ev_q [$];
    logic [3:0]  exp_row;

    mat_key_scan #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DB_DEPTH(4),
        .FIFO_DEPTH(4), .COL_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_in(col_in), .btn(btn),
        .frame_tick(frame_tick), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_press(evt_press), .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key connects its row drive to its column.
    always_comb begin
        col_in = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_n[r]) col_in = col_in | keys[r*COLS +: COLS];
        end
    end

    // Log every event handed to the consumer.
    always @(posedge clk) begin
        if (!rst && evt_valid && evt_ready) ev_q.push_back({evt_code, evt_press});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; keys = '0; evt_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_row_n", 32'(row_n), 32'h e);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_btn", 32'(btn), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        cyc = 0;

        // Idle scan pattern
        for (int i = 0; i < 64; i++) begin
            goto(i);
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            chk($sformatf("idle_row_n_%0d", i), 32'(row_n), 32'(exp_row));
            chk($sformatf("idle_tick_%0d", i), 32'(frame_tick), 32'((i % 16) == 15));
        end
        goto(64);
        chk("idle_btn", 32'(btn), 0);
        chk("idle_valid", 32'(evt_valid), 0);

        // Key 6 held from reset, then released
        keys = 16'h0040; evt_ready = 1'b1;
        do_reset();
        ev_q.delete();
        goto(63);  chk("k6_btn_pre", 32'(btn), 0);
        goto(64);  chk("k6_btn_set", 32'(btn), 32'h0040);
                   chk("k6_valid_pre", 32'(evt_valid), 0);
        goto(65);  chk("k6_valid", 32'(evt_valid), 1);
                   chk("k6_code", 32'(evt_code), 6);
                   chk("k6_press", 32'(evt_press), 1);
        goto(66);  chk("k6_popped", 32'(evt_valid), 0);
        keys = 16'h0000;
        goto(127); chk("k6_btn_hold", 32'(btn), 32'h0040);
        goto(128); chk("k6_btn_clr", 32'(btn), 0);
        goto(129); chk("k6_rel_valid", 32'(evt_valid), 1);
                   chk("k6_rel_code", 32'(evt_code), 6);
                   chk("k6_rel_press", 32'(evt_press), 0);
        goto(130); chk("k6_ev_count", 32'(ev_q.size()), 2);
        if (ev_q.size() == 2) begin
            chk("k6_ev0", 32'(ev_q[0]), 32'h0d);
            chk("k6_ev1", 32'(ev_q[1]), 32'h0c);
        end

        // Key 6 bouncing 1,0,1,1,1 then held
        keys = 16'h0040; evt_ready = 1'b1;
        do_reset();
        ev_q.delete();
        goto(16);  keys = 16'h0000;
        goto(32);  keys = 16'h0040;
        goto(80);  chk("bnc_btn_f5", 32'(btn), 0);
        goto(95);  chk("bnc_btn_pre", 32'(btn), 0);
        goto(96);  chk("bnc_btn_set", 32'(btn), 32'h0040);
        goto(100); chk("bnc_ev_count", 32'(ev_q.size()), 1);
        if (ev_q.size() == 1) chk("bnc_ev0", 32'(ev_q[0]), 32'h0d);

        // Keys 15, 3, 9 together, consumer stalled
        keys = 16'h8208; evt_ready = 1'b0;
        do_reset();
        goto(64);  chk("ord_btn", 32'(btn), 32'h8208);
        goto(67);  chk("ord_valid", 32'(evt_valid), 1);
                   chk("ord_head0", 32'(evt_code), 3);
                   chk("ord_press0", 32'(evt_press), 1);
                   chk("ord_ovf", 32'(overflow), 0);
        evt_ready = 1'b1;
        goto(68);  chk("ord_head1", 32'(evt_code), 9);
        goto(69);  chk("ord_head2", 32'(evt_code), 15);
                   chk("ord_press2", 32'(evt_press), 1);
        goto(70);  chk("ord_empty", 32'(evt_valid), 0);

        // Six keys together: four kept, two dropped
        keys = 16'h5126; evt_ready = 1'b0;
        do_reset();
        goto(68);  chk("ovf_pre", 32'(overflow), 0);
                   chk("ovf_valid", 32'(evt_valid), 1);
        goto(69);  chk("ovf_set", 32'(overflow), 1);
        goto(70);  chk("ovf_head0", 32'(evt_code), 1);
                   chk("ovf_press0", 32'(evt_press), 1);
        evt_ready = 1'b1;
        goto(71);  chk("ovf_head1", 32'(evt_code), 2);
        goto(72);  chk("ovf_head2", 32'(evt_code), 5);
        goto(73);  chk("ovf_head3", 32'(evt_code), 8);
        goto(74);  chk("ovf_drained", 32'(evt_valid), 0);
                   chk("ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        goto(75);  clr_ovf = 1'b0;
                   chk("ovf_cleared", 32'(overflow), 0);

        // Reset during a drain of three pending keys
        keys = 16'h8208; evt_ready = 1'b0;
        do_reset();
        goto(64);  chk("rd_btn_pre", 32'(btn), 32'h8208);
        rst = 1'b1; keys = 16'h0000;
        goto(65);  chk("rd_valid", 32'(evt_valid), 0);
                   chk("rd_btn", 32'(btn), 0);
                   chk("rd_row_n", 32'(row_n), 32'h e);
                   chk("rd_tick", 32'(frame_tick), 0);
        rst = 1'b0; cyc = 0; evt_ready = 1'b1;
        ev_q.delete();
        goto(100); chk("rd_no_events", 32'(ev_q.size()), 0);
                   chk("rd_valid_late", 32'(evt_valid), 0);
                   chk("rd_btn_late", 32'(btn), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
